// File: rtl/intpol2_d4_fifo_feeder.sv
`default_nettype none
// ============================================================================
// Module      : intpol2_d4_fifo_feeder
// Description : Streams ilen words from a source memory into the interpolator
//               input FIFO. Define INTPOL2_D4_FEED_SKID_EN for a 1-entry skid.
// Revision    : 1.0 - initial release
// ============================================================================
module intpol2_d4_fifo_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   ilen,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  Afull,
  input  logic                  Full,
  output logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH:0]   wr_cnt
);

  localparam int c_LEN_W = DATA_WIDTH + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_FIN   = 2'd3;

  logic [1:0]            r_state;
  logic [c_LEN_W-1:0]    r_len;
  logic [c_LEN_W-1:0]    r_rd_cnt;
  logic [c_LEN_W-1:0]    r_wr_cnt;
  logic                  r_pend;
  logic [c_LEN_W-1:0]    w_rd_nxt;
  logic [c_LEN_W-1:0]    w_wr_nxt;
  logic                  w_rd_block;
  logic                  w_rd_en;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_wdata;

`ifdef INTPOL2_D4_FEED_SKID_EN
  logic                  r_skid_vld;
  logic [DATA_WIDTH-1:0] r_skid_data;

  // Reads stall while a word is parked or about to be parked, so the skid
  // entry and a fresh return can never both be pending.
  assign w_rd_block = r_skid_vld | (r_pend & Full);
  assign w_we       = (r_skid_vld | r_pend) & ~Full;
  assign w_wdata    = r_skid_vld ? r_skid_data : mem_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else if (clear) begin
      r_skid_vld  <= 1'b0;
    end else if (r_pend & Full) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= mem_rdata;
    end else if (!Full) begin
      r_skid_vld  <= 1'b0;
    end
  end
`else
  logic w_unused_full;

  assign w_unused_full = Full;
  assign w_rd_block    = 1'b0;
  assign w_we          = r_pend;
  assign w_wdata       = mem_rdata;
`endif

  assign w_rd_en  = (r_state == c_READ) && !Afull && (r_rd_cnt < r_len) && !w_rd_block;
  assign w_rd_nxt = r_rd_cnt + c_LEN_W'(w_rd_en);
  assign w_wr_nxt = r_wr_cnt + c_LEN_W'(w_we);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= c_IDLE;
      r_len    <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_pend   <= 1'b0;
    end else if (clear) begin
      // The write presented in this cycle did reach the FIFO, so it is counted.
      r_state  <= c_IDLE;
      r_pend   <= 1'b0;
      r_wr_cnt <= w_wr_nxt;
    end else begin
      r_pend   <= w_rd_en;
      r_rd_cnt <= w_rd_nxt;
      r_wr_cnt <= w_wr_nxt;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_len    <= ilen;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_state  <= (ilen == '0) ? c_FIN : c_READ;
          end
        end
        c_READ: begin
          if (w_rd_nxt == r_len) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (w_wr_nxt == r_len) r_state <= c_FIN;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign mem_rd_en    = w_rd_en;
  assign mem_addr     = r_rd_cnt[ADDR_WIDTH-1:0];
  assign Write_Enable = w_we;
  assign fifo_wdata   = w_we ? w_wdata : '0;
  assign busy         = (r_state != c_IDLE);
  assign done         = (r_state == c_FIN);
  assign wr_cnt       = r_wr_cnt;

endmodule
`default_nettype wire
